subtractor_serial: RTL and testbench
====================================

// Module: subtractor_serial
//
// PURPOSE
//   Bit-serial subtractor: computes {bout,Diff} = A - B - bin, one bit per clock, LSB first.
//   Counterpart to the combinational adder: it undoes an addition, over several cycles,
//   in a small area.
//   Used where a result may take WIDTH cycles and area matters, e.g. operand
//   recovery (Sum - B) in arithmetic self-check paths.
//   Operands enter via a start pulse; the result is signalled with a one-cycle done pulse.
//
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2)
//
// PORTS
//   clk     in   1      clock; all state updates on rising edge
//   rst     in   1      synchronous reset, active-high
//   start   in   1      request; sampled only in IDLE
//   A       in   WIDTH  minuend, latched on accepted start
//   B       in   WIDTH  subtrahend, latched on accepted start
//   bin     in   1      borrow-in, latched on accepted start
//   Diff    out  WIDTH  difference (A-B-bin) mod 2^WIDTH
//   bout    out  1      borrow-out; 1 iff A < B+bin (unsigned)
//   busy    out  1      1 while state != IDLE
//   done    out  1      one-cycle pulse: Diff/bout valid
//
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state=IDLE; Diff=0, bout=0, busy=0, done=0; counter and
//     operand/shift registers cleared. Reset wins over start and over any state.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     - IDLE:
//       - start=1: latch A, B and bin into shift registers; borrow reg=bin; cnt=0; ->RUN.
//       - start=0: hold; Diff and bout keep their last result.
//     - RUN: each edge computes one bit.
//       - d = a0 ^ b0 ^ brw
//       - brw' = (~a0 & b0) | (~(a0 ^ b0) & brw)
//       - d shifts into the Diff shift reg from the MSB end; the operand regs shift right.
//       - cnt increments. On the edge where cnt==WIDTH-1: ->DONE.
//     - DONE: done=1 for exactly this cycle; Diff holds the full result; bout=final brw;
//       next edge ->IDLE.
//   - Latency: start accepted at edge 0; done high in the cycle following edge WIDTH.
//     Next start is accepted at the earliest on edge WIDTH+2 (i.e. in IDLE).
//   - start while busy (RUN or DONE) is ignored. There is no queueing and the operands
//     are not re-latched.
//   - Input changes after the accepting edge have no effect on the result.
//   - Diff and bout are registered outputs. They update only on the DONE transition (not
//     bit-by-bit on the ports) and hold until the next result or reset.
//   - The internal shift reg is separate from the Diff port register.
//   - Arithmetic: unsigned, mod 2^WIDTH. The true value is -2^WIDTH*bout + Diff.
//     Extremes wrap cleanly, e.g. 0-0-1 gives all-ones with bout=1.
//   - cnt width: $clog2(WIDTH). No cycle is skipped or repeated when WIDTH is a power
//     of two.
//
// TESTING
//   1. Reset: rst=1 two cycles -> Diff=0, bout=0, busy=0, done=0; start held high during
//      rst is not accepted.
//   2. A=4'b1110, B=4'b0111, bin=0, start pulse -> done 4 cycles later; Diff=4'b0111,
//      bout=0; busy high for 5 cycles.
//   3. A=4'b0111, B=4'b1110, bin=0 -> Diff=4'b1001, bout=1. Check that
//      A == Diff + B mod 16.
//   4. A=0, B=0, bin=1 -> Diff=4'b1111, bout=1. A=4'b1111, B=4'b1111, bin=0 -> Diff=0,
//      bout=0.
//   5. Start held high with operands changed every cycle while busy -> exactly one result
//      per accepted start, equal to the first-latched operands. The next start is accepted
//      the first cycle after done.
//   6. rst asserted at RUN cycle 2 -> next cycle IDLE, all outputs 0, no done pulse.
//      A fresh start then gives a correct result.

Source files
------------

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: {bout,Diff} = A - B - bin, one bit per clock, LSB first.
// Start pulse latches operands; a one-cycle done pulse marks a valid result.
module subtractor_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] Diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             brw_d;
  logic [WIDTH-1:0] sh_d;

  // One full-subtractor cell applied to the current LSBs.
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ brw_q;
    brw_d = (~a_q[0] & b_q[0])
          | (~(a_q[0] ^ b_q[0]) & brw_q);
    sh_d  = {bit_d, sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            brw_q   <= bin;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sh_q  <= sh_d;
          brw_q <= brw_d;
          cnt_q <= cnt_q + 1'b1;
          // Ports see only the finished word, never partial bits.
          if (cnt_q == CNT_LAST) begin
            diff_q  <= sh_d;
            bout_q  <= brw_d;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial (WIDTH=4).
// Hand-computed vectors; all checks go through chk.
module tb_subtractor_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic [W-1:0] Diff;
  logic         bout;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  subtractor_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .bin  (bin),
    .Diff (Diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one start, then follow busy until it drops.
  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic bi,
                     output int done_at,
                     output int busy_n,
                     output int ndone);
    A = a; B = b; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    done_at = -1; busy_n = 0; ndone = 0;
    while (busy && busy_n < 20) begin
      if (done) begin
        done_at = busy_n;
        ndone++;
      end
      busy_n++;
      tick();
    end
  endtask

  int da, bn, nd, k;

  initial begin
    // 1. reset with start held high
    rst = 1'b1; start = 1'b1; A = 4'hA; B = 4'h3;
    tick();
    tick();
    chk("rst_diff", 32'(Diff), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    start = 1'b0; rst = 1'b0;
    tick();
    chk("rst_no_accept", 32'(busy), 0);

    // 2. 14 - 7 = 7
    run(4'b1110, 4'b0111, 1'b0, da, bn, nd);
    chk("t2_done_at", 32'(da), 4);
    chk("t2_busy_n", 32'(bn), 5);
    chk("t2_ndone", 32'(nd), 1);
    chk("t2_diff", 32'(Diff), 32'b0111);
    chk("t2_bout", 32'(bout), 0);
    chk("t2_done_low", 32'(done), 0);

    // 3. 7 - 14 wraps to 9 with borrow
    run(4'b0111, 4'b1110, 1'b0, da, bn, nd);
    chk("t3_diff", 32'(Diff), 32'b1001);
    chk("t3_bout", 32'(bout), 1);
    chk("t3_recover", 32'((Diff + 4'b1110) & 4'hF),
        32'b0111);
    tick();
    chk("t3_hold", 32'(Diff), 32'b1001);

    // 4. extremes
    run(4'h0, 4'h0, 1'b1, da, bn, nd);
    chk("t4a_diff", 32'(Diff), 32'hF);
    chk("t4a_bout", 32'(bout), 1);
    run(4'hF, 4'hF, 1'b0, da, bn, nd);
    chk("t4b_diff", 32'(Diff), 0);
    chk("t4b_bout", 32'(bout), 0);

    // 5. start held, operands churn: 9-3-1 = 5
    A = 4'd9; B = 4'd3; bin = 1'b1; start = 1'b1;
    tick();
    k = 0;
    while (!done && k < 20) begin
      A = 4'($urandom); B = 4'($urandom);
      bin = 1'($urandom);
      k++;
      tick();
    end
    chk("t5_done_at", 32'(k), 4);
    chk("t5_diff", 32'(Diff), 5);
    chk("t5_bout", 32'(bout), 0);
    A = 4'd2; B = 4'd5; bin = 1'b0;
    tick();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_one_done", 32'(done), 0);
    tick();
    chk("t5_reaccept", 32'(busy), 1);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      k++;
      tick();
    end
    chk("t5b_done_at", 32'(k), 4);
    chk("t5b_diff", 32'(Diff), 13);
    chk("t5b_bout", 32'(bout), 1);
    tick();

    // 6. reset mid-run
    A = 4'd5; B = 4'd2; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_diff", 32'(Diff), 0);
    chk("t6_bout", 32'(bout), 0);
    chk("t6_done", 32'(done), 0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) nd++;
      tick();
    end
    chk("t6_quiet", 32'(nd), 0);
    run(4'd5, 4'd2, 1'b0, da, bn, nd);
    chk("t6_diff2", 32'(Diff), 3);
    chk("t6_bout2", 32'(bout), 0);
    chk("t6_ndone2", 32'(nd), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
